alu_nbit_seq: RTL and testbench

Parametrised N-bit ALU with a registered valid/ready interface and an iterative multiply mode. It extends the ripple-slice ALU operation set to a full word and adds signed-correct SLT, a zero flag and an unsigned shift-add multiply. It sits between the register-file read stage and writeback in the datapath, with one operation in flight at a time.

---
 rtl/alu_nbit_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: WIDTH-bit ALU with a valid/ready handshake on both sides.
// One operation is in flight at a time. Logic, add, sub and SLT operations
// finish on the accept edge. MUL is an unsigned shift-add multiply that takes
// WIDTH further clock edges.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, op             operands and opcode, sampled on accept
//                        op: 000 AND, 001 OR, 010 ADD, 011 NAND,
//                            100 NOR, 101 MUL, 110 SUB, 111 SLT
//   out_valid/out_ready  result handshake (out_valid high only in HOLD)
//   result               registered result
//   carry_out            adder carry out of the MSB (0 for logic ops and MUL)
//   overflow             signed overflow (ADD/SUB/SLT) or
//                        upper product half nonzero (MUL)
//   zero                 result == 0
module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Single-cycle datapath, fed directly from the inputs; its values are
    // only captured on the accept edge.
    logic             binv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             less;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;
    logic [2*WIDTH-1:0] acc_next;

    assign binv    = op[2] & op[1];
    assign b_eff   = binv ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, binv};
    // carry into the MSB is recovered from the MSB sum bit
    assign add_ovf = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
    assign less    = sum[WIDTH-1] ^ add_ovf;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            3'b000: alu_res = a & b;
            3'b001: alu_res = a | b;
            3'b011: alu_res = ~(a & b);
            3'b100: alu_res = ~(a | b);
            3'b010, 3'b110: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            3'b111: begin
                alu_res   = {{(WIDTH-1){1'b0}}, less};
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            default: ;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand when the
    // current multiplier LSB is set.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // last step: publish the product directly from the adder
                    result_d = acc_next[WIDTH-1:0];
                    carry_d  = 1'b0;
                    ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = ~|result_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq at WIDTH=8: directed vector table, hold/back-pressure
// and mid-MUL reset sequences, then random operations against a model.
module tb_alu_nbit_seq;

    localparam int W = 8;
    localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, NAND = 3'b011,
                           NOR = 3'b100, MUL = 3'b101, SUB = 3'b110, SLT = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero;

    int vectors = 0;
    int miscompares = 0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         c, v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference built from arithmetic definitions of each operation.
    function automatic void model(input logic [W-1:0] x, y, input logic [2:0] o,
                                  output logic [W-1:0] r, output logic c, v);
        int ux = int'(x), uy = int'(y);
        int sx = (ux >= 128) ? ux - 256 : ux;
        int sy = (uy >= 128) ? uy - 256 : uy;
        int d;
        r = '0; c = 1'b0; v = 1'b0;
        case (o)
            AND_: r = x & y;
            OR_:  r = x | y;
            NAND: r = ~(x & y);
            NOR:  r = ~(x | y);
            ADD: begin
                r = 8'(ux + uy); c = (ux + uy) > 255;
                d = sx + sy; v = (d > 127) || (d < -128);
            end
            SUB, SLT: begin
                r = 8'(ux - uy); c = (ux >= uy);
                d = sx - sy; v = (d > 127) || (d < -128);
                if (o == SLT) r = (sx < sy) ? 8'd1 : 8'd0;
            end
            MUL: begin
                d = ux * uy; r = 8'(d); v = d > 255;
            end
            default: ;
        endcase
    endfunction

    // Issue one op, keep in_valid high with junk operands while busy (must be
    // ignored), check latency and outputs, optionally stall out_ready, then
    // complete the handshake. lat = edges after the accept edge until
    // out_valid is seen: 0 for single-cycle ops (visible in cycle 1), WIDTH for MUL.
    task automatic run_op(input logic [W-1:0] ta, tb_, input logic [2:0] top,
                          input logic [W-1:0] er, input logic ec, ev, input int stall);
        int n;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        check("latency", 32'(n), (top == MUL) ? 32'(W) : 32'd0);
        check("result", 32'(result), 32'(er));
        check("carry_out", 32'(carry_out), 32'(ec));
        check("overflow", 32'(overflow), 32'(ev));
        check("zero", 32'(zero), 32'(er == '0));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(er));
            check("hold_zero", 32'(zero), 32'(er == '0));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vt[14];
        logic [W-1:0] ra, rb, er;
        logic [2:0]   ro;
        logic         ec, ev;

        vt[0]  = '{8'h7F, 8'h01, ADD,  8'h80, 1'b0, 1'b1};
        vt[1]  = '{8'h05, 8'h05, SUB,  8'h00, 1'b1, 1'b0};
        vt[2]  = '{8'h80, 8'h7F, SLT,  8'h01, 1'b1, 1'b1};
        vt[3]  = '{8'h7F, 8'h80, SLT,  8'h00, 1'b0, 1'b1};
        vt[4]  = '{8'h10, 8'h11, MUL,  8'h10, 1'b0, 1'b1};
        vt[5]  = '{8'h0F, 8'h0F, MUL,  8'hE1, 1'b0, 1'b0};
        vt[6]  = '{8'hF0, 8'h3C, AND_, 8'h30, 1'b0, 1'b0};
        vt[7]  = '{8'hF0, 8'h0F, OR_,  8'hFF, 1'b0, 1'b0};
        vt[8]  = '{8'hFF, 8'hFF, NAND, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{8'hF0, 8'h0F, NOR,  8'h00, 1'b0, 1'b0};
        vt[10] = '{8'hFF, 8'h01, ADD,  8'h00, 1'b1, 1'b0};
        vt[11] = '{8'h00, 8'h01, SUB,  8'hFF, 1'b0, 1'b0};
        vt[12] = '{8'hFF, 8'hFF, MUL,  8'h01, 1'b0, 1'b1};
        vt[13] = '{8'h00, 8'h55, MUL,  8'h00, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].op, vt[i].res, vt[i].c, vt[i].v, 0);

        // back-pressure: NOR result held for 3 stalled cycles
        run_op(8'hF0, 8'h0F, NOR, 8'h00, 1'b0, 1'b0, 3);
        run_op(8'h10, 8'h11, MUL, 8'h10, 1'b0, 1'b1, 2);

        // reset in the middle of a multiply
        a = 8'h10; b = 8'h11; op = MUL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("mul_busy", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        run_op(8'h01, 8'h01, ADD, 8'h02, 1'b0, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); ro = 3'($urandom);
            model(ra, rb, ro, er, ec, ev);
            run_op(ra, rb, ro, er, ec, ev, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
